// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage issuing req/ready word fetches into the IF/ID slot,
// with a one-entry skid buffer for decode stalls and redirect flushing.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic [31:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
    logic        valid_q, valid_d, skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
    logic [31:0] tgt, pc_next;
    logic        resp, adv;
    assign tgt       = redirect_target & ~32'd3;
    assign pc_next   = fetch_pc_q + 32'd4;
    assign resp      = (state_q == WAIT) && imem_ready;
    assign adv       = !stall || !valid_q;
    assign imem_req  = state_q != IDLE;
    assign imem_addr = addr_q;
    assign if_instr  = instr_q;
    assign if_pc     = pc_q;
    assign if_pc_plus4 = pc4_q;
    assign if_valid  = valid_q;
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (redirect_valid) begin
            valid_d    = 1'b0;
            instr_d    = '0;
            skid_v_d   = 1'b0;
            fetch_pc_d = tgt;
            // an in-flight request must still complete before the new target can go out
            if (state_q != IDLE && !imem_ready) begin
                state_d = DRAIN;
            end else begin
                state_d = WAIT;
                addr_d  = tgt;
            end
        end else begin
            if (adv && (skid_v_q || resp)) begin
                instr_d = skid_v_q ? skid_instr_q : imem_rdata;
                pc_d    = skid_v_q ? skid_pc_q : addr_q;
                pc4_d   = pc_d + 32'd4;
            end
            if (adv) begin
                valid_d  = skid_v_q || resp;
                skid_v_d = 1'b0;
            end else if (resp) begin
                skid_v_d     = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = addr_q;
            end
            if (state_q == IDLE && !skid_v_d) begin
                state_d = WAIT;
                addr_d  = fetch_pc_q;
            end else if (resp) begin
                fetch_pc_d = pc_next;
                addr_d     = pc_next;
                state_d    = skid_v_d ? IDLE : WAIT;
            end else if (state_q == DRAIN && imem_ready) begin
                addr_d  = fetch_pc_q;
                state_d = skid_v_d ? IDLE : WAIT;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= '0;
            pc_q         <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            skid_v_q     <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a behavioural instruction memory and an
// in-order scoreboard of the PCs decode should see.
module tb_instr_fetch_unit;
    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] KEY = 32'hAAAA_AAAA;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        if_valid;
    logic        auto_mem = 1'b1;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = '0;
    int          mem_wait = 0;
    int          cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];

    instr_fetch_unit #(.RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cnt <= (!imem_req || imem_ready) ? 0 : cnt + 1;

    always @(negedge clock) begin
        imem_ready = auto_mem ? (imem_req && cnt >= mem_wait) : man_ready;
        imem_rdata = auto_mem ? (imem_ready ? (imem_addr ^ KEY) : 32'hDEAD_BEEF) : man_rdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // a valid slot with stall low is taken by decode at the coming edge
    always @(negedge clock) begin
        if (!reset && if_valid === 1'b1 && stall === 1'b0) begin
            chk("sb_avail", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                logic [31:0] e;
                e = q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, e ^ KEY);
                chk("sb_pc4", if_pc_plus4, e + 32'd4);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_from(input logic [31:0] base, input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(base + 32'(4 * i));
    endtask

    task automatic redirect_to(input logic [31:0] t, input int n);
        redirect_valid  = 1'b1;
        redirect_target = t;
        @(negedge clock);
        #1;
        expect_from(t & ~32'd3, n);
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_pc4", if_pc_plus4, 0);
        reset = 1'b0;
        expect_from(RPC, 64);
        step(1);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, RPC);
        chk("t1_valid0", if_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("t1_valid", if_valid, 1);
            chk("t1_pc", if_pc, RPC + 32'(4 * k));
        end
        mem_wait = 2;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                step(1);
                chk("t2_gap_valid", if_valid, 0);
                chk("t2_addr_hold", imem_addr, RPC + 32'h0C + 32'(4 * k));
            end
            step(1);
            chk("t2_valid", if_valid, 1);
            chk("t2_pc", if_pc, RPC + 32'h0C + 32'(4 * k));
        end
        mem_wait = 0;
        redirect_to(32'h0000_0000, 64);
        chk("t3_rd_valid", if_valid, 0);
        chk("t3_rd_instr", if_instr, 0);
        chk("t3_rd_addr", imem_addr, 32'h0);
        chk("t3_rd_req", imem_req, 1);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("t3_pc", if_pc, 32'(4 * k));
        end
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("t3_hold_pc", if_pc, 32'h08);
            chk("t3_hold_valid", if_valid, 1);
            chk("t3_hold_req", imem_req, 0);
        end
        stall = 1'b0;
        step(1);
        chk("t3_skid_pc", if_pc, 32'h0C);
        chk("t3_reissue", imem_addr, 32'h10);
        step(1);
        chk("t3_next_pc", if_pc, 32'h10);
        step(3);
        chk("t4_pre_pc", if_pc, 32'h1C);
        auto_mem  = 1'b0;
        man_ready = 1'b0;
        chk("t4_addr", imem_addr, 32'h20);
        redirect_to(32'h0000_1003, 64);
        chk("t4_valid", if_valid, 0);
        chk("t4_instr", if_instr, 0);
        chk("t4_drain_req", imem_req, 1);
        chk("t4_drain_addr", imem_addr, 32'h20);
        step(1);
        chk("t4_drain_addr2", imem_addr, 32'h20);
        chk("t4_valid2", if_valid, 0);
        man_ready = 1'b1;
        man_rdata = 32'h20 ^ KEY;
        step(1);
        chk("t4_new_addr", imem_addr, 32'h1000);
        chk("t4_drop_valid", if_valid, 0);
        auto_mem = 1'b1;
        step(1);
        chk("t4_valid3", if_valid, 1);
        chk("t4_pc", if_pc, 32'h1000);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(1);
            chk("t5_hold_pc", if_pc, 32'h1000);
            chk("t5_skid_req", imem_req, 0);
        end
        auto_mem  = 1'b0;
        man_ready = 1'b1;
        man_rdata = 32'h1234_5678;
        redirect_to(32'h0000_2000, 64);
        chk("t5_valid", if_valid, 0);
        chk("t5_instr", if_instr, 0);
        chk("t5_addr", imem_addr, 32'h2000);
        chk("t5_req", imem_req, 1);
        man_ready = 1'b0;
        step(1);
        chk("t5_no_stale", if_valid, 0);
        chk("t5_addr2", imem_addr, 32'h2000);
        auto_mem = 1'b1;
        stall    = 1'b0;
        step(1);
        chk("t5_valid2", if_valid, 1);
        chk("t5_pc", if_pc, 32'h2000);
        auto_mem  = 1'b0;
        man_ready = 1'b0;
        reset     = 1'b1;
        step(1);
        q.delete();
        chk("t6_req", imem_req, 0);
        chk("t6_addr", imem_addr, RPC);
        chk("t6_valid", if_valid, 0);
        chk("t6_instr", if_instr, 0);
        chk("t6_pc", if_pc, 0);
        chk("t6_pc4", if_pc_plus4, 0);
        reset     = 1'b0;
        man_ready = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        step(1);
        chk("t6_req2", imem_req, 1);
        chk("t6_addr2", imem_addr, RPC);
        chk("t6_late_valid", if_valid, 0);
        man_ready = 1'b0;
        expect_from(RPC, 16);
        step(1);
        chk("t6_wait_valid", if_valid, 0);
        chk("t6_wait_addr", imem_addr, RPC);
        auto_mem = 1'b1;
        step(1);
        chk("t6_valid2", if_valid, 1);
        chk("t6_pc2", if_pc, RPC);
        step(1);
        chk("t6_pc3", if_pc, RPC + 32'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
